ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the RV64 integer pipeline. Accepts one decoded instruction per cycle from decode/issue, selects ALU operands (register, PC or immediate), drives the combinational `alu`, and holds results in a 2-entry in-order output buffer for the memory stage. A valid/ready handshake on both sides keeps `in_ready` free of any combinational path from `out_ready`.

## Interface
Parameters:
- `XLEN`, 64, datapath width; only 64 is supported.
- `DEPTH`, 2, output buffer entries; fixed at 2.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `flush`  in  1  discard all buffered entries and any same-cycle input.
- `in_valid`  in  1  input instruction valid.
- `in_ready`  out  1  stage can accept an instruction.
- `in_pc`  in  64  instruction PC.
- `in_rs1`, `in_rs2`  in  5 each  source register indices.
- `in_rs1_val`, `in_rs2_val`  in  64 each  register-file read values.
- `in_imm`  in  64  sign-extended immediate.
- `in_src1_pc`  in  1  operand 1 source: 1 = `in_pc`, 0 = rs1.
- `in_src2_imm`  in  1  operand 2 source: 1 = `in_imm`, 0 = rs2.
- `in_op`  in  `alu_op`  ALU operation.
- `in_is_word`  in  1  32-bit W-form operation.
- `in_rd`  in  5  destination register.
- `in_rd_wen`  in  1  writes `in_rd`.
- `out_valid`  out  1  head entry valid.
- `out_ready`  in  1  downstream accepts the head.
- `out_pc`, `out_result`  out  64 each  head PC and ALU result.
- `out_rd`  out  5  head destination register.
- `out_rd_wen`  out  1  head write enable.

## Operation
- Operand 1 = `in_src1_pc ? in_pc : rs1_value`; operand 2 = `in_src2_imm ? in_imm : rs2_value`. rs*_value is the register-file value, or the forwarded value when forwarding is enabled.
- `alu` is instantiated combinationally. Its result is written into the buffer tail on the accept edge. Sign-extension for W-ops is done inside `alu`.
- Push when `in_valid && in_ready && !flush`. Pop when `out_valid && out_ready && !flush`.
- `count` ranges from 0 to 2. `in_ready = !rst && (count < 2)`. A pop in the same cycle does not raise `in_ready` while full.
- Push and pop in the same cycle at `count == 1`: the head leaves, the new entry becomes the head, and `count` stays 1.
- `out_*` reflect the head entry. When `count == 0`, `out_valid = 0` and `out_pc`, `out_result`, `out_rd`, `out_rd_wen` are all 0.
- Flush: on the next edge `count` becomes 0. The same-cycle input is dropped and the same-cycle pop does not count as a transfer. `in_ready` follows `count` as normal.
- Reset takes priority over flush and handshakes.
- Results leave in acceptance order.

## Timing
- Reset: `count = 0`, all entries cleared. During reset `out_valid = 0`, all `out_*` = 0 and `in_ready = 0`. `in_ready = 1` in the first cycle after reset deasserts.
- Latency: an instruction accepted at edge N appears at the head in cycle N+1 if the buffer was empty.
- Throughput: 1 instruction per cycle while `out_ready` stays high.
- Back-pressure: `out_ready = 0` for 2+ cycles fills the buffer and drops `in_ready` on the second accepted instruction's edge.
- Head fields must hold stable while `out_valid && !out_ready`.
- Reset asserted mid-stream: the buffer is emptied on that edge and any in-flight handshake is ignored.

## Configuration
- Macro `EX_FWD_EN`.
- Defined: rs1/rs2 bypass from the buffer.
  - For each source, if a buffered entry has `rd_wen`, `rd != 0` and `rd == in_rsX`, use that entry's result. The youngest matching entry wins.
  - No match, or source index 0: use `in_rsX_val`.
  - An entry being popped in the same cycle is still eligible.
  - Adds a combinational path from buffer state to the ALU inputs only.
- Undefined: `in_rs*_val` is used unconditionally, and `in_rs1`/`in_rs2` are unused.

## Test plan
- Basic ADD: `in_op=ADD`, rs1=5, imm=`-3`, `in_src2_imm=1`, `out_ready=1` -> next cycle `out_valid=1`, `out_result=2`. Buffer empty after the pop edge.
- W-op and PC source:
  - `ADD`, `is_word=1`, rs1=`0x7FFFFFFF`, rs2=1 -> `out_result=0xFFFFFFFF80000000`.
  - `in_src1_pc=1`, pc=`0x1000`, imm=4 -> `out_result=0x1004`.
- Back-pressure:
  - `out_ready=0`, three consecutive valid inputs -> only two accepted, `in_ready=0` after the second.
  - Raise `out_ready` -> results emerge in order, `in_ready` returns the cycle after the first pop.
- Flush: two entries buffered, `flush=1` together with `in_valid=1` -> next cycle `out_valid=0`, `count=0`, flushed input never emerges.
- Forwarding (`EX_FWD_EN`):
  - Accept `ADD x3 = 10+20`, then, while x3 is still buffered, `SUB rs1=x3` with stale `in_rs1_val=0` and rs2=5 -> second result = 25.
  - Same sequence with rd=x0 -> second result = `-5`.
- Reset mid-stream: two entries buffered, `rst=1` for one cycle -> all `out_*` = 0 and `in_ready=0` during reset, `in_ready=1` after, no stale result emitted.

Source files
------------

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_stage (with ex_pkg and alu)
// Brief    : RV64 execute stage. Operand select, combinational ALU and a
//            2-entry in-order output buffer. Optional macro EX_FWD_EN enables
//            rs1/rs2 bypass from buffered results.
// Revision : 1.0
// ============================================================================

package ex_pkg;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op;
endpackage

module alu #(
    parameter int XLEN = 64
) (
    input  ex_pkg::alu_op   op,
    input  logic            is_word,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result
);
    import ex_pkg::*;

    logic [5:0]      w_shamt;
    logic [XLEN-1:0] w_a_zx;
    logic [XLEN-1:0] w_a_sx;
    logic [XLEN-1:0] w_raw;

    // W-forms shift the low word only, so the shifted-in bits must come from bit 31
    assign w_shamt = is_word ? {1'b0, b[4:0]} : b[5:0];
    assign w_a_zx  = is_word ? {{(XLEN-32){1'b0}}, a[31:0]} : a;
    assign w_a_sx  = is_word ? {{(XLEN-32){a[31]}}, a[31:0]} : a;

    always_comb begin
        w_raw = '0;
        case (op)
            ALU_ADD:  w_raw = a + b;
            ALU_SUB:  w_raw = a - b;
            ALU_SLL:  w_raw = a << w_shamt;
            ALU_SLT:  w_raw = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: w_raw = {{(XLEN-1){1'b0}}, (a < b)};
            ALU_XOR:  w_raw = a ^ b;
            ALU_SRL:  w_raw = w_a_zx >> w_shamt;
            ALU_SRA:  w_raw = $signed(w_a_sx) >>> w_shamt;
            ALU_OR:   w_raw = a | b;
            ALU_AND:  w_raw = a & b;
            default:  w_raw = '0;
        endcase
    end

    assign result = is_word ? {{(XLEN-32){w_raw[31]}}, w_raw[31:0]} : w_raw;
endmodule

module ex_stage #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [4:0]      in_rs1,
    input  logic [4:0]      in_rs2,
    input  logic [XLEN-1:0] in_rs1_val,
    input  logic [XLEN-1:0] in_rs2_val,
    input  logic [XLEN-1:0] in_imm,
    input  logic            in_src1_pc,
    input  logic            in_src2_imm,
    input  ex_pkg::alu_op   in_op,
    input  logic            in_is_word,
    input  logic [4:0]      in_rd,
    input  logic            in_rd_wen,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_result,
    output logic [4:0]      out_rd,
    output logic            out_rd_wen
);
    localparam logic [1:0] c_full = 2'(DEPTH);

    logic [XLEN-1:0] r_pc  [DEPTH];
    logic [XLEN-1:0] r_res [DEPTH];
    logic [4:0]      r_rd  [DEPTH];
    logic            r_wen [DEPTH];
    logic            r_head;
    logic [1:0]      r_count;

    logic            w_push;
    logic            w_pop;
    logic            w_tail;
    logic            w_has;
    logic [XLEN-1:0] w_rs1;
    logic [XLEN-1:0] w_rs2;
    logic [XLEN-1:0] w_op1;
    logic [XLEN-1:0] w_op2;
    logic [XLEN-1:0] w_alu_res;

`ifdef EX_FWD_EN
    logic w_young;

    // The younger entry is checked last so it overrides an older match
    always_comb begin
        w_young = ~r_head;
        w_rs1   = in_rs1_val;
        w_rs2   = in_rs2_val;
        if (r_count != 2'd0 && r_wen[r_head] && r_rd[r_head] != 5'd0) begin
            if (r_rd[r_head] == in_rs1) w_rs1 = r_res[r_head];
            if (r_rd[r_head] == in_rs2) w_rs2 = r_res[r_head];
        end
        if (r_count == c_full && r_wen[w_young] && r_rd[w_young] != 5'd0) begin
            if (r_rd[w_young] == in_rs1) w_rs1 = r_res[w_young];
            if (r_rd[w_young] == in_rs2) w_rs2 = r_res[w_young];
        end
    end
`else
    logic [9:0] w_unused_rs;

    assign w_unused_rs = {in_rs1, in_rs2};
    assign w_rs1       = in_rs1_val;
    assign w_rs2       = in_rs2_val;
`endif

    assign w_op1 = in_src1_pc  ? in_pc  : w_rs1;
    assign w_op2 = in_src2_imm ? in_imm : w_rs2;

    alu #(.XLEN(XLEN)) u_alu (
        .op      (in_op),
        .is_word (in_is_word),
        .a       (w_op1),
        .b       (w_op2),
        .result  (w_alu_res)
    );

    assign in_ready = !rst && (r_count < c_full);
    assign w_has    = !rst && (r_count != 2'd0);
    assign w_push   = in_valid && in_ready && !flush;
    assign w_pop    = out_valid && out_ready && !flush;
    // With two entries the tail is the head when empty, the other slot otherwise
    assign w_tail   = r_head ^ r_count[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= 1'b0;
            r_count <= 2'd0;
            for (int i = 0; i < DEPTH; i++) begin
                r_pc[i]  <= '0;
                r_res[i] <= '0;
                r_rd[i]  <= '0;
                r_wen[i] <= 1'b0;
            end
        end else if (flush) begin
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_pc[w_tail]  <= in_pc;
                r_res[w_tail] <= w_alu_res;
                r_rd[w_tail]  <= in_rd;
                r_wen[w_tail] <= in_rd_wen;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign out_valid  = w_has;
    assign out_pc     = w_has ? r_pc[r_head]  : '0;
    assign out_result = w_has ? r_res[r_head] : '0;
    assign out_rd     = w_has ? r_rd[r_head]  : '0;
    assign out_rd_wen = w_has ? r_wen[r_head] : 1'b0;
endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_stage
// Brief    : Scoreboard bench for ex_stage; expected results queued on accept,
//            compared on pop. Forwarding expectations follow EX_FWD_EN.
// Revision : 1.0
// ============================================================================
module tb_ex_stage;
    import ex_pkg::*;

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] res;
        logic [4:0]  rd;
        logic        wen;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_pc;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [63:0] in_rs1_val;
    logic [63:0] in_rs2_val;
    logic [63:0] in_imm;
    logic        in_src1_pc;
    logic        in_src2_imm;
    alu_op       in_op;
    logic        in_is_word;
    logic [4:0]  in_rd;
    logic        in_rd_wen;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [63:0] out_result;
    logic [4:0]  out_rd;
    logic        out_rd_wen;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t cur;
    exp_t sb[$];

    ex_stage #(.XLEN(64), .DEPTH(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_pc       (in_pc),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_rs1_val  (in_rs1_val),
        .in_rs2_val  (in_rs2_val),
        .in_imm      (in_imm),
        .in_src1_pc  (in_src1_pc),
        .in_src2_imm (in_src2_imm),
        .in_op       (in_op),
        .in_is_word  (in_is_word),
        .in_rd       (in_rd),
        .in_rd_wen   (in_rd_wen),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_result  (out_result),
        .out_rd      (out_rd),
        .out_rd_wen  (out_rd_wen)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [63:0] pc, input logic [63:0] rs1v, input logic [63:0] rs2v,
                         input logic [63:0] imm, input logic s1pc, input logic s2imm,
                         input alu_op op, input logic word, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd, input logic wen,
                         input logic [63:0] res);
        in_valid    = 1'b1;
        in_pc       = pc;
        in_rs1_val  = rs1v;
        in_rs2_val  = rs2v;
        in_imm      = imm;
        in_src1_pc  = s1pc;
        in_src2_imm = s2imm;
        in_op       = op;
        in_is_word  = word;
        in_rs1      = rs1;
        in_rs2      = rs2;
        in_rd       = rd;
        in_rd_wen   = wen;
        cur         = '{pc: pc, res: res, rd: rd, wen: wen};
    endtask

    // Monitor: compare on every pop, then track accepts/discards for later pops
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && !flush && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_out: got result %h pc %h, expected no output", out_result, out_pc);
                end else begin
                    e = sb.pop_front();
                    chk("out_result", out_result, e.res);
                    chk("out_pc", out_pc, e.pc);
                    chk("out_rd", {59'd0, out_rd}, {59'd0, e.rd});
                    chk("out_rd_wen", {63'd0, out_rd_wen}, {63'd0, e.wen});
                end
            end
            if (rst || flush) sb.delete();
            else if (in_valid && in_ready) sb.push_back(cur);
        end
    end

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        issue(64'h0, 64'h0, 64'h0, 64'h0, 1'b0, 1'b0, ALU_ADD, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 64'h0);
        in_valid = 1'b1;
        repeat (2) tick();
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_result", out_result, 64'd0);
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

        // Basic ADD with negative immediate
        out_ready = 1'b1;
        issue(64'h100, 64'd5, 64'd0, -64'sd3, 1'b0, 1'b1, ALU_ADD, 1'b0, 5'd1, 5'd0, 5'd7, 1'b1, 64'd2);
        tick();
        in_valid = 1'b0;
        chk("add_latency_valid", {63'd0, out_valid}, 64'd1);
        tick();
        chk("add_drained", {63'd0, out_valid}, 64'd0);

        // Back-to-back W-op, PC source, SRAW, SLTU
        issue(64'h200, 64'h7FFF_FFFF, 64'd1, 64'd0, 1'b0, 1'b0, ALU_ADD, 1'b1, 5'd2, 5'd3, 5'd8, 1'b1, 64'hFFFF_FFFF_8000_0000);
        tick();
        issue(64'h1000, 64'd0, 64'd0, 64'd4, 1'b1, 1'b1, ALU_ADD, 1'b0, 5'd0, 5'd0, 5'd9, 1'b1, 64'h1004);
        tick();
        issue(64'h208, 64'h8000_0000, 64'd0, 64'd4, 1'b0, 1'b1, ALU_SRA, 1'b1, 5'd4, 5'd0, 5'd10, 1'b1, 64'hFFFF_FFFF_F800_0000);
        tick();
        issue(64'h20C, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 1'b0, ALU_SLTU, 1'b0, 5'd5, 5'd6, 5'd11, 1'b0, 64'd1);
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        chk("stream_drained", {63'd0, out_valid}, 64'd0);

        // Back-pressure: third input must wait
        out_ready = 1'b0;
        issue(64'h300, 64'd100, 64'd1, 64'd0, 1'b0, 1'b0, ALU_SUB, 1'b0, 5'd1, 5'd2, 5'd12, 1'b1, 64'd99);
        tick();
        chk("bp_ready_after_1", {63'd0, in_ready}, 64'd1);
        issue(64'h304, 64'hF0, 64'h0F, 64'd0, 1'b0, 1'b0, ALU_OR, 1'b0, 5'd1, 5'd2, 5'd13, 1'b1, 64'hFF);
        tick();
        chk("bp_full_ready", {63'd0, in_ready}, 64'd0);
        issue(64'h308, 64'd1, 64'd3, 64'd0, 1'b0, 1'b0, ALU_SLL, 1'b0, 5'd1, 5'd2, 5'd14, 1'b1, 64'd8);
        tick();
        chk("bp_still_full", {63'd0, in_ready}, 64'd0);
        chk("bp_head_hold", out_result, 64'd99);
        out_ready = 1'b1;
        tick();
        chk("bp_ready_after_pop", {63'd0, in_ready}, 64'd1);
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        chk("bp_drained", {63'd0, out_valid}, 64'd0);

        // Flush with two buffered entries and a same-cycle input
        out_ready = 1'b0;
        issue(64'h400, 64'd1, 64'd1, 64'd0, 1'b0, 1'b0, ALU_ADD, 1'b0, 5'd1, 5'd2, 5'd15, 1'b1, 64'd2);
        tick();
        issue(64'h404, 64'd2, 64'd2, 64'd0, 1'b0, 1'b0, ALU_ADD, 1'b0, 5'd1, 5'd2, 5'd16, 1'b1, 64'd4);
        tick();
        flush = 1'b1;
        issue(64'h408, 64'd3, 64'd3, 64'd0, 1'b0, 1'b0, ALU_ADD, 1'b0, 5'd1, 5'd2, 5'd17, 1'b1, 64'd6);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
        out_ready = 1'b1;
        repeat (2) tick();
        chk("flush_no_emerge", {63'd0, out_valid}, 64'd0);

        // Dependent pair: x3 buffered, then consumer with stale register value
        out_ready = 1'b0;
        issue(64'h500, 64'd10, 64'd20, 64'd0, 1'b0, 1'b0, ALU_ADD, 1'b0, 5'd1, 5'd2, 5'd3, 1'b1, 64'd30);
        tick();
`ifdef EX_FWD_EN
        issue(64'h504, 64'd0, 64'd5, 64'd0, 1'b0, 1'b0, ALU_SUB, 1'b0, 5'd3, 5'd4, 5'd5, 1'b1, 64'd25);
`else
        issue(64'h504, 64'd0, 64'd5, 64'd0, 1'b0, 1'b0, ALU_SUB, 1'b0, 5'd3, 5'd4, 5'd5, 1'b1, -64'sd5);
`endif
        tick();
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        // Writes to x0 must never be bypassed
        out_ready = 1'b0;
        issue(64'h600, 64'd10, 64'd20, 64'd0, 1'b0, 1'b0, ALU_ADD, 1'b0, 5'd1, 5'd2, 5'd0, 1'b1, 64'd30);
        tick();
        issue(64'h604, 64'd0, 64'd5, 64'd0, 1'b0, 1'b0, ALU_SUB, 1'b0, 5'd0, 5'd4, 5'd6, 1'b1, -64'sd5);
        tick();
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();

        // Reset mid-stream with in-flight handshake
        out_ready = 1'b0;
        issue(64'h700, 64'd7, 64'd7, 64'd0, 1'b0, 1'b0, ALU_XOR, 1'b0, 5'd1, 5'd2, 5'd18, 1'b1, 64'd0);
        tick();
        issue(64'h704, 64'd6, 64'd3, 64'd0, 1'b0, 1'b0, ALU_AND, 1'b0, 5'd1, 5'd2, 5'd19, 1'b1, 64'd2);
        tick();
        rst = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_out_pc", out_pc, 64'd0);
        chk("mid_rst_out_result", out_result, 64'd0);
        chk("mid_rst_out_rd", {59'd0, out_rd}, 64'd0);
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("after_rst_in_ready", {63'd0, in_ready}, 64'd1);
        repeat (2) tick();
        chk("after_rst_no_stale", {63'd0, out_valid}, 64'd0);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
